// File: rtl/icon_gen.sv
// icon_gen: per-frame robot icon sprite generator for the VGA overlay.
// Latches location/heading on the vertical-sync leading edge, computes the
// icon-box hit two columns ahead, and reads a 16x16 2bpp sprite through a
// two-stage pipeline so icon_pixel lines up with the incoming pixel_column.
module icon_gen #(
  // Name of the sprite source. The build flow converts this file into
  // ICON_DATA, which keeps the ROM free of simulation-only file loading.
  parameter string         ICON_FILE     = "icon.mem",
  // Sprite image: entry {heading, dy[3:0], dx[3:0]} at bits [2*addr +: 2].
  parameter logic [4095:0] ICON_DATA     = '0,
  parameter bit            VS_ACTIVE_LOW = 1'b1,
  parameter int            BLINK_FRAMES  = 16,
  parameter int            LATENCY       = 2
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [9:0] pixel_row,
  input  logic [9:0] pixel_column,
  input  logic       vert_sync,
  input  logic [8:0] LocX_reg,
  input  logic [8:0] LocY_reg,
  input  logic [2:0] heading_reg,
  input  logic       blink_en,
  output logic [1:0] icon_pixel,
  output logic       frame_tick
);

  if (BLINK_FRAMES < 1 || LATENCY != 2 || ICON_FILE == "") begin : g_param_check
    $error("icon_gen: BLINK_FRAMES must be >= 1, LATENCY must be 2, ICON_FILE must be named");
  end

  localparam int             CNT_W     = (BLINK_FRAMES < 1) ? 1 : $clog2(2 * BLINK_FRAMES);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(2 * BLINK_FRAMES - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLINK_FRAMES);
  localparam logic [10:0]    LOOKAHEAD = 11'(LATENCY);
  localparam logic [10:0]    HALF_BOX  = 11'd8;

  logic             vs_prev;
  logic             vs_now;
  logic             vs_was;
  logic             sync_edge;
  logic [8:0]       loc_x_l;
  logic [8:0]       loc_y_l;
  logic [2:0]       heading_l;
  logic             valid;
  logic [CNT_W-1:0] blink_cnt;
  logic             blanked;
  logic [10:0]      x0;
  logic [10:0]      y0;
  logic [10:0]      col_eval;
  logic [10:0]      row_eval;
  logic [10:0]      dx;
  logic [10:0]      dy;
  logic             in_box;
  logic             hit_q;
  logic [10:0]      addr_q;

  // Sync edge detection in asserted-level terms, independent of polarity.
  assign vs_now     = VS_ACTIVE_LOW ? ~vert_sync : vert_sync;
  assign vs_was     = VS_ACTIVE_LOW ? ~vs_prev : vs_prev;
  assign sync_edge  = vs_now & ~vs_was;
  assign frame_tick = sync_edge;

  // Frame latch: location and heading only change on the sync edge, so a
  // frame is always drawn from one consistent set of values.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      vs_prev   <= ~VS_ACTIVE_LOW;
      loc_x_l   <= '0;
      loc_y_l   <= '0;
      heading_l <= '0;
      valid     <= 1'b0;
    end else begin
      vs_prev <= vert_sync;
      if (sync_edge) begin
        loc_x_l   <= LocX_reg;
        loc_y_l   <= LocY_reg;
        heading_l <= heading_reg;
        valid     <= 1'b1;
      end
    end
  end

  // Blink frame counter: steps on each latch edge, held at zero when disabled.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      blink_cnt <= '0;
    end else if (!blink_en) begin
      blink_cnt <= '0;
    end else if (sync_edge) begin
      blink_cnt <= (blink_cnt == CNT_LAST) ? '0 : blink_cnt + 1'b1;
    end
  end

  assign blanked = (blink_cnt >= CNT_BLANK);

  // Box geometry in 11-bit two's complement. The worst-case offsets stay
  // well inside +/-2048, so a wrapped difference can never alias into 0..15,
  // and 0 <= d <= 15 reduces to the upper seven bits being zero.
  assign x0       = {2'b00, loc_x_l} - HALF_BOX;
  assign y0       = {2'b00, loc_y_l} - HALF_BOX;
  assign col_eval = {1'b0, pixel_column} + LOOKAHEAD;
  assign row_eval = {1'b0, pixel_row};
  assign dx       = col_eval - x0;
  assign dy       = row_eval - y0;
  assign in_box   = (dx[10:4] == 7'd0) && (dy[10:4] == 7'd0);

  // Stage 1: register the hit decision and sprite address.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      hit_q  <= 1'b0;
      addr_q <= '0;
    end else begin
      hit_q  <= in_box;
      addr_q <= {heading_l, dy[3:0], dx[3:0]};
    end
  end

  // Stage 2: synchronous ROM read, gated by frame validity and blink.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      icon_pixel <= 2'b00;
    end else if (hit_q && valid && !blanked) begin
      icon_pixel <= ICON_DATA[{addr_q, 1'b0} +: 2];
    end else begin
      icon_pixel <= 2'b00;
    end
  end

endmodule

// File: tb/tb_icon_gen.sv
// tb_icon_gen: drives reduced display sweeps into icon_gen and compares every
// cycle against a pixel-level reference model of the icon placement rules.
module tb_icon_gen;

  localparam int   BF     = 2;
  localparam logic VS_ON  = 1'b0;
  localparam logic VS_OFF = 1'b1;
  localparam int   BLANK_ROW = 600;
  localparam int   BLANK_COL = 700;

  // Sprite contents by heading: 0 all 11, 1..3 = heading, 4 = dx, 5 = dy, else a hash.
  function automatic logic [1:0] rom_entry(input int h, input int dy, input int dx);
    int mix;
    mix = dx ^ (dy * 3) ^ (h * 5);
    case (h)
      0:       return 2'b11;
      1:       return 2'b01;
      2:       return 2'b10;
      3:       return 2'b11;
      4:       return dx[1:0];
      5:       return dy[1:0];
      default: return mix[1:0];
    endcase
  endfunction

  function automatic logic [4095:0] build_rom();
    logic [4095:0] img;
    img = '0;
    for (int h = 0; h < 8; h++)
      for (int y = 0; y < 16; y++)
        for (int x = 0; x < 16; x++)
          img[(h * 256 + y * 16 + x) * 2 +: 2] = rom_entry(h, y, x);
    return img;
  endfunction

  localparam logic [4095:0] ROM_IMG = build_rom();

  logic       clk;
  logic       sys_rst;
  logic [9:0] pixel_row;
  logic [9:0] pixel_column;
  logic       vert_sync;
  logic [8:0] LocX_reg;
  logic [8:0] LocY_reg;
  logic [2:0] heading_reg;
  logic       blink_en;
  logic [1:0] icon_pixel;
  logic       frame_tick;

  icon_gen #(
    .ICON_FILE     ("icon.mem"),
    .ICON_DATA     (ROM_IMG),
    .VS_ACTIVE_LOW (1'b1),
    .BLINK_FRAMES  (BF),
    .LATENCY       (2)
  ) dut (
    .sys_clk      (clk),
    .sys_rst      (sys_rst),
    .pixel_row    (pixel_row),
    .pixel_column (pixel_column),
    .vert_sync    (vert_sync),
    .LocX_reg     (LocX_reg),
    .LocY_reg     (LocY_reg),
    .heading_reg  (heading_reg),
    .blink_en     (blink_en),
    .icon_pixel   (icon_pixel),
    .frame_tick   (frame_tick)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: what the icon should look like this frame.
  int         m_x, m_y, m_h, m_cnt;
  bit         m_valid;
  logic       m_vs_prev;
  logic [1:0] pipe0, pipe1;

  // Per-frame observations of the DUT output.
  int st_nz, st_minc, st_maxc, st_minr, st_maxr, st_ticks;
  int st_val[4];

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic clear_stats();
    st_nz = 0; st_ticks = 0;
    st_minc = 1_000_000; st_maxc = -1;
    st_minr = 1_000_000; st_maxr = -1;
    for (int i = 0; i < 4; i++) st_val[i] = 0;
  endtask

  // Icon pixel that should appear in the cycle whose column is c + 2.
  function automatic logic [1:0] model_pix(input int r, input int c);
    int dx, dy;
    if (!m_valid || m_cnt >= BF) return 2'b00;
    dx = c + 2 - (m_x - 8);
    dy = r - (m_y - 8);
    if (dx < 0 || dx > 15 || dy < 0 || dy > 15) return 2'b00;
    return rom_entry(m_h, dy, dx);
  endfunction

  task automatic tick(input int r, input int c, input logic vs);
    logic       exp_tick;
    logic [1:0] exp_pix;
    @(posedge clk);
    #1;
    pixel_row    = 10'(r);
    pixel_column = 10'(c);
    vert_sync    = vs;
    @(negedge clk);
    exp_tick = sys_rst && (vs == VS_ON) && (m_vs_prev != VS_ON);
    exp_pix  = sys_rst ? pipe1 : 2'b00;
    check("icon_pixel", int'(icon_pixel), int'(exp_pix));
    check("frame_tick", int'(frame_tick), int'(exp_tick));
    if (frame_tick) st_ticks++;
    if (icon_pixel != 2'b00 && r < BLANK_ROW) begin
      st_nz++;
      if (c < st_minc) st_minc = c;
      if (c > st_maxc) st_maxc = c;
      if (r < st_minr) st_minr = r;
      if (r > st_maxr) st_maxr = r;
    end
    st_val[icon_pixel]++;
    if (!sys_rst) begin
      m_x = 0; m_y = 0; m_h = 0; m_cnt = 0; m_valid = 1'b0;
      pipe0 = 2'b00; pipe1 = 2'b00;
      m_vs_prev = VS_ON;
    end else begin
      pipe1 = pipe0;
      pipe0 = model_pix(r, c);
      if (!blink_en) m_cnt = 0;
      else if (exp_tick) m_cnt = (m_cnt + 1) % (2 * BF);
      if (exp_tick) begin
        m_x = int'(LocX_reg); m_y = int'(LocY_reg); m_h = int'(heading_reg);
        m_valid = 1'b1;
      end
      m_vs_prev = vs;
    end
  endtask

  // One reduced frame: sync pulse in blanking, then rows row_lo..row_hi of
  // columns 0..col_hi. Optional mid-frame input change at chg_row, and
  // optional per-cycle input churn during the active area.
  task automatic run_frame(input int x, input int y, input int h, input bit be,
                           input int row_lo, input int row_hi, input int col_hi,
                           input int chg_row, input int chg_x, input int chg_h,
                           input bit churn);
    LocX_reg = 9'(x); LocY_reg = 9'(y); heading_reg = 3'(h); blink_en = be;
    clear_stats();
    repeat (3) tick(BLANK_ROW, BLANK_COL, VS_OFF);
    repeat (4) tick(BLANK_ROW, BLANK_COL, VS_ON);
    repeat (3) tick(BLANK_ROW, BLANK_COL, VS_OFF);
    for (int r = row_lo; r <= row_hi; r++) begin
      if (r == chg_row) begin
        LocX_reg = 9'(chg_x);
        heading_reg = 3'(chg_h);
      end
      for (int c = 0; c <= col_hi; c++) begin
        if (churn) begin
          LocX_reg    = 9'($urandom_range(0, 511));
          LocY_reg    = 9'($urandom_range(0, 511));
          heading_reg = 3'($urandom_range(0, 7));
        end
        tick(r, c, VS_OFF);
      end
    end
    repeat (3) tick(BLANK_ROW, BLANK_COL, VS_OFF);
    check("ticks_per_frame", st_ticks, 1);
  endtask

  initial begin
    #(40 * 200_000);
    $display("FAIL watchdog: simulation time limit reached, n_vec=%0d", n_vec);
    $fatal(1, "watchdog");
  end

  initial begin
    bit vis_exp [8] = '{1, 0, 0, 1, 1, 0, 0, 1};
    int ry;
    sys_rst = 1'b0;
    pixel_row = '0; pixel_column = '0; vert_sync = VS_OFF;
    LocX_reg = '0; LocY_reg = '0; heading_reg = '0; blink_en = 1'b0;
    m_vs_prev = VS_ON; pipe0 = '0; pipe1 = '0;
    m_x = 0; m_y = 0; m_h = 0; m_cnt = 0; m_valid = 1'b0;
    clear_stats();

    // Reset held with random inputs, then released mid-frame without a sync edge.
    for (int i = 0; i < 5; i++) begin
      LocX_reg    = 9'($urandom_range(0, 511));
      LocY_reg    = 9'($urandom_range(0, 511));
      heading_reg = 3'($urandom_range(0, 7));
      blink_en    = 1'($urandom_range(0, 1));
      tick($urandom_range(0, 599), $urandom_range(0, 799), 1'($urandom_range(0, 1)));
    end
    check("reset_ticks", st_ticks, 0);
    check("reset_nz", st_nz, 0);
    blink_en = 1'b0;
    heading_reg = 3'd0;
    sys_rst = 1'b1;
    clear_stats();
    for (int r = 0; r <= 10; r++)
      for (int c = 0; c <= 31; c++)
        tick(r, c, VS_OFF);
    check("pre_sync_nz", st_nz, 0);
    check("pre_sync_ticks", st_ticks, 0);

    // Placement at (100, 50), solid sprite.
    run_frame(100, 50, 0, 1'b0, 40, 59, 127, -1, 0, 0, 1'b0);
    check("place_nz", st_nz, 256);
    check("place_val11", st_val[3], 256);
    check("place_minc", st_minc, 92);
    check("place_maxc", st_maxc, 107);
    check("place_minr", st_minr, 42);
    check("place_maxr", st_maxr, 57);

    // Tear-free: LocX moves to 200 at row 45; only the next frame follows it.
    run_frame(100, 50, 0, 1'b0, 40, 59, 223, 45, 200, 0, 1'b0);
    check("tear_nz", st_nz, 256);
    check("tear_minc", st_minc, 92);
    check("tear_maxc", st_maxc, 107);
    run_frame(200, 50, 0, 1'b0, 40, 59, 223, -1, 0, 0, 1'b0);
    check("moved_nz", st_nz, 256);
    check("moved_minc", st_minc, 192);
    check("moved_maxc", st_maxc, 207);

    // Heading lookup, with a mid-frame heading change that must wait a frame.
    run_frame(100, 50, 2, 1'b0, 40, 59, 127, 45, 100, 3, 1'b0);
    check("head2_val10", st_val[2], 256);
    check("head2_val11", st_val[3], 0);
    run_frame(100, 50, 3, 1'b0, 40, 59, 127, -1, 0, 0, 1'b0);
    check("head3_val11", st_val[3], 256);

    // Clipping at the top-left corner.
    run_frame(3, 3, 0, 1'b0, 0, 15, 31, -1, 0, 0, 1'b0);
    check("clip_nz", st_nz, 99);
    check("clip_minc", st_minc, 2);
    check("clip_maxc", st_maxc, 10);
    check("clip_minr", st_minr, 0);
    check("clip_maxr", st_maxr, 10);
    run_frame(3, 3, 4, 1'b0, 0, 15, 31, -1, 0, 0, 1'b0);

    // Blink: counter goes 1,2,3,0,... from a held-zero start.
    for (int f = 0; f < 8; f++) begin
      run_frame(100, 50, 0, 1'b1, 44, 47, 127, -1, 0, 0, 1'b0);
      check("blink_frame_nz", st_nz, vis_exp[f] ? 64 : 0);
    end
    for (int f = 0; f < 3; f++) begin
      run_frame(100, 50, 0, 1'b0, 44, 47, 127, -1, 0, 0, 1'b0);
      check("noblink_nz", st_nz, 64);
    end

    // Randomized frames with input churn during active video.
    for (int f = 0; f < 5; f++) begin
      ry = $urandom_range(0, 60);
      run_frame($urandom_range(0, 200), ry, $urandom_range(0, 7), 1'($urandom_range(0, 1)),
                (ry > 10) ? ry - 10 : 0, ry + 10, 223, -1, 0, 0, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
